// File: rtl/bit_stream_operand_serializer.sv
// LSB-first serializer feeding the bit-serial adder: one operand pair per valid/ready accept.
// Define GUARD_BITS_EN to append one A=B=0 guard cycle after each word.
module bit_stream_operand_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             A,
    output logic             B,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             guard
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGuard} state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic            r_bit_valid;
    logic            r_first;
    logic            r_last;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_cnt_last;
    logic [CntW-1:0] w_cnt_inc;

    assign w_cnt_last = (r_cnt == CntLast);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            StIdle:  w_in_ready = 1'b1;
            StGuard: w_in_ready = 1'b1;
`ifdef GUARD_BITS_EN
            StShift: w_in_ready = 1'b0;
`else
            StShift: w_in_ready = w_cnt_last;
`endif
            default: w_in_ready = 1'b0;
        endcase
    end

`ifdef GUARD_BITS_EN
    logic r_guard;
`endif

    // Shift registers are cleared whenever no data bit is on the line, so A/B
    // come straight from flop bit 0 and read 0 in IDLE and GUARD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_bit_valid <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
`ifdef GUARD_BITS_EN
            r_guard     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state     <= StShift;
            r_cnt       <= '0;
            r_sh_a      <= op_a;
            r_sh_b      <= op_b;
            r_bit_valid <= 1'b1;
            r_first     <= 1'b1;
            r_last      <= 1'b0;
`ifdef GUARD_BITS_EN
            r_guard     <= 1'b0;
`endif
        end else begin
            case (r_state)
                StShift: begin
                    r_first <= 1'b0;
                    if (w_cnt_last) begin
                        r_cnt  <= '0;
                        r_sh_a <= '0;
                        r_sh_b <= '0;
                        r_last <= 1'b0;
`ifdef GUARD_BITS_EN
                        r_state     <= StGuard;
                        r_bit_valid <= 1'b1;
                        r_guard     <= 1'b1;
`else
                        r_state     <= StIdle;
                        r_bit_valid <= 1'b0;
`endif
                    end else begin
                        r_cnt       <= w_cnt_inc;
                        r_sh_a      <= r_sh_a >> 1;
                        r_sh_b      <= r_sh_b >> 1;
                        r_bit_valid <= 1'b1;
                        r_last      <= (w_cnt_inc == CntLast);
                    end
                end
                StGuard: begin
                    r_state     <= StIdle;
                    r_bit_valid <= 1'b0;
                    r_first     <= 1'b0;
                    r_last      <= 1'b0;
`ifdef GUARD_BITS_EN
                    r_guard     <= 1'b0;
`endif
                end
                StIdle: begin
                    r_bit_valid <= 1'b0;
                    r_first     <= 1'b0;
                    r_last      <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign A         = r_sh_a[0];
    assign B         = r_sh_b[0];
    assign bit_valid = r_bit_valid;
    assign first_bit = r_first;
    assign last_bit  = r_last;
`ifdef GUARD_BITS_EN
    assign guard     = r_guard;
`else
    assign guard     = 1'b0;
`endif

endmodule

// File: doc/bit_stream_operand_serializer.md
# bit_stream_operand_serializer

Upstream feeder for the bit-serial adder FSM. Accepts two WIDTH-bit operands through a valid/ready handshake and streams them out LSB-first, one bit per clock, on the A/B lines the serial adder samples. It also emits framing strobes so downstream logic can locate word boundaries. An optional guard cycle drives A=B=0 after each word so the adder's carry is output as a final sum bit before the next word starts.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock shared with the serial adder
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  op_a/op_b are valid this cycle
- in_ready  output  1  serializer will accept an operand pair at this edge
- op_a  input  WIDTH  first operand
- op_b  input  WIDTH  second operand
- A  output  1  serial bit of op_a, LSB first; registered
- B  output  1  serial bit of op_b, LSB first; registered
- bit_valid  output  1  A/B carry a data bit or guard bit this cycle
- first_bit  output  1  A/B carry bit 0 of a word
- last_bit  output  1  A/B carry bit WIDTH-1 of a word
- guard  output  1  current cycle is the guard cycle; constant 0 when GUARD_BITS_EN is undefined

## Operation
- Registers: sh_a and sh_b (WIDTH each), bit counter cnt ($clog2(WIDTH) bits), state register.
- States:
  - IDLE: no word is being sent.
  - SHIFT: data bits are being emitted.
  - GUARD: present only with GUARD_BITS_EN.
- Accept: a transfer occurs at a rising edge where in_valid && in_ready. It loads sh_a/sh_b, clears cnt and enters SHIFT.
- in_ready is combinational from state and cnt; it never depends on in_valid:
  - 1 in IDLE.
  - 1 in GUARD.
  - 1 in SHIFT when cnt==WIDTH-1, but only when GUARD_BITS_EN is undefined.
  - 0 otherwise.
- SHIFT, each cycle:
  - A=sh_a[0], B=sh_b[0] are registered outputs.
  - At the edge, shift right by 1 and increment cnt.
- At cnt==WIDTH-1:
  - With GUARD_BITS_EN: go to GUARD.
  - Without GUARD_BITS_EN: if an accept occurs, reload and stay in SHIFT; otherwise go to IDLE.
- GUARD: A=B=0, bit_valid=1, guard=1 for exactly one cycle. Next state is SHIFT if an accept occurs, else IDLE.
- IDLE outputs: A=B=0, bit_valid=first_bit=last_bit=guard=0.
- Strobes:
  - first_bit=1 only in the cycle carrying bit 0.
  - last_bit=1 only in the cycle carrying bit WIDTH-1.
  - Neither strobe is asserted in GUARD.
- Operands are captured at accept. Changes to op_a/op_b after that edge have no effect on the word in flight.
- in_valid while in_ready=0 is ignored; the producer must hold its data.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0, sh_a=sh_b=0.
  - A=B=bit_valid=first_bit=last_bit=guard=0, in_ready=1.
  - Takes effect immediately, including mid-word; the partial word is discarded.
- Latency: if a word is accepted at edge k, bit i is on A/B during the cycle following edge k+i, for i=0..WIDTH-1.
- Word period:
  - WIDTH cycles without GUARD_BITS_EN.
  - WIDTH+1 cycles with GUARD_BITS_EN.
  - Back-to-back accepts give gapless bit_valid.
- Accept in the final SHIFT cycle (no guard) or in GUARD: the next word's bit 0 follows with no IDLE cycle between.
- Reset release: the first accept is possible at the first rising edge with rst_n=1.

## Configuration
- GUARD_BITS_EN defined:
  - GUARD state exists.
  - Each word is followed by one A=B=0 cycle with guard=1, which clears the adder carry and outputs the carry-out as a sum bit.
  - in_ready is low in the last SHIFT cycle.
- GUARD_BITS_EN undefined:
  - No GUARD state; guard is tied to 0.
  - Words stream back-to-back.
  - Carry handling between words is the consumer's responsibility.

## Test plan
- Reset mid-word: assert rst_n=0 after 3 bits of a word -> in the same cycle all outputs are 0 and in_ready=1. After release, a new word starts cleanly from bit 0.
- Single word, WIDTH=8, op_a=0x5A, op_b=0x3C -> A=0,1,0,1,1,0,1,0 and B=0,0,1,1,1,1,0,0 on 8 consecutive bit_valid cycles. first_bit is on the first of these cycles, last_bit on the eighth; then IDLE.
- Back-to-back, macro undefined: in_valid held high with 0xFF/0x01 then 0x00/0x80 -> 16 gapless bit_valid cycles. in_ready is high only at the accept edges; the second word's first_bit immediately follows the first word's last_bit.
- Back-to-back, GUARD_BITS_EN defined, same stimulus -> 18 bit_valid cycles: 8 data, 1 guard (A=B=0, guard=1), 8 data, 1 guard. No first_bit or last_bit in guard cycles.
- Handshake stall: in_valid pulses while in_ready=0, op_a changes mid-word -> the word in flight is unchanged and the stalled request is ignored. A held in_valid is accepted at the next in_ready edge.
- WIDTH=2 boundary: op_a=2'b10, op_b=2'b11 -> A=0,1 and B=1,1; first_bit and last_bit fall on adjacent cycles; the counter wraps correctly.
